vga_dither_6b: RTL



---
 rtl/vga_dither_6b.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/vga_dither_6b.sv
// 8-to-6-bit VGA colour reduction with 2x2 ordered dithering and a matched sync delay.
// Optional build macro TEMPORAL_DITHER_EN adds a per-frame rotation of the threshold.
module vga_dither_6b #(
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic       CLK_VIDEO,
    input  logic       RESET_N,
    input  logic       CE_PIX,
    input  logic       DITHER_EN,
    input  logic [7:0] VGA_R_IN,
    input  logic [7:0] VGA_G_IN,
    input  logic [7:0] VGA_B_IN,
    input  logic       VGA_HS_IN,
    input  logic       VGA_VS_IN,
    output logic [5:0] VGA_R_OUT,
    output logic [5:0] VGA_G_OUT,
    output logic [5:0] VGA_B_OUT,
    output logic       VGA_HS_OUT,
    output logic       VGA_VS_OUT
);

    localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    // Top six bits plus one when the dropped fraction beats the threshold, clamped at 63.
    function automatic logic [5:0] dither_chan(input logic [7:0] c, input logic [1:0] t,
                                               input logic en);
        logic [6:0] sum;
        if (en) begin
            sum = {1'b0, c[7:2]} + ((c[1:0] > t) ? 7'd1 : 7'd0);
        end else begin
            sum = {1'b0, c[7:2]};
        end
        if (sum[6]) begin
            dither_chan = 6'd63;
        end else begin
            dither_chan = sum[5:0];
        end
    endfunction

    logic       x0_q, x0_d;
    logic       y0_q, y0_d;
    logic       hs_prev_q, hs_prev_d;
    logic       vs_prev_q, vs_prev_d;
    logic [7:0] r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
    logic       hs1_q, hs1_d, vs1_q, vs1_d;
    logic [1:0] t1_q, t1_d;
    logic [5:0] r2_q, r2_d, g2_q, g2_d, b2_q, b2_d;
    logic       hs2_q, hs2_d, vs2_q, vs2_d;
`ifdef TEMPORAL_DITHER_EN
    logic [1:0] frame_q, frame_d;
`endif

    logic       hs_edge_s, vs_edge_s;
    logic [1:0] t_raw_s, t_eff_s;

    // Sync edge detection, phase counters and both pipeline stages.
    always_comb begin
        hs_edge_s = (VGA_HS_IN != SYNC_IDLE) && (hs_prev_q == SYNC_IDLE);
        vs_edge_s = (VGA_VS_IN != SYNC_IDLE) && (vs_prev_q == SYNC_IDLE);
        t_raw_s   = {x0_q ^ y0_q, y0_q};
`ifdef TEMPORAL_DITHER_EN
        t_eff_s   = t_raw_s + frame_q;
        frame_d   = frame_q;
`else
        t_eff_s   = t_raw_s;
`endif
        x0_d      = x0_q;
        y0_d      = y0_q;
        hs_prev_d = hs_prev_q;
        vs_prev_d = vs_prev_q;
        r1_d      = r1_q;
        g1_d      = g1_q;
        b1_d      = b1_q;
        hs1_d     = hs1_q;
        vs1_d     = vs1_q;
        t1_d      = t1_q;
        r2_d      = r2_q;
        g2_d      = g2_q;
        b2_d      = b2_q;
        hs2_d     = hs2_q;
        vs2_d     = vs2_q;

        if (CE_PIX) begin
            hs_prev_d = VGA_HS_IN;
            vs_prev_d = VGA_VS_IN;
            x0_d      = hs_edge_s ? 1'b0 : ~x0_q;
            // Frame start wins over line start so every frame begins on row 0.
            if (vs_edge_s) begin
                y0_d = 1'b0;
            end else if (hs_edge_s) begin
                y0_d = ~y0_q;
            end else begin
                y0_d = y0_q;
            end
`ifdef TEMPORAL_DITHER_EN
            frame_d = vs_edge_s ? (frame_q + 2'd1) : frame_q;
`endif
            r1_d  = VGA_R_IN;
            g1_d  = VGA_G_IN;
            b1_d  = VGA_B_IN;
            hs1_d = VGA_HS_IN;
            vs1_d = VGA_VS_IN;
            t1_d  = t_eff_s;
            r2_d  = dither_chan(r1_q, t1_q, DITHER_EN);
            g2_d  = dither_chan(g1_q, t1_q, DITHER_EN);
            b2_d  = dither_chan(b1_q, t1_q, DITHER_EN);
            hs2_d = hs1_q;
            vs2_d = vs1_q;
        end else begin
            x0_d = x0_q;
            y0_d = y0_q;
        end
    end

    // State update with synchronous reset taking priority over the pixel enable.
    always_ff @(posedge CLK_VIDEO) begin
        if (!RESET_N) begin
            x0_q      <= 1'b0;
            y0_q      <= 1'b0;
            hs_prev_q <= SYNC_IDLE;
            vs_prev_q <= SYNC_IDLE;
            r1_q      <= 8'd0;
            g1_q      <= 8'd0;
            b1_q      <= 8'd0;
            hs1_q     <= SYNC_IDLE;
            vs1_q     <= SYNC_IDLE;
            t1_q      <= 2'd0;
            r2_q      <= 6'd0;
            g2_q      <= 6'd0;
            b2_q      <= 6'd0;
            hs2_q     <= SYNC_IDLE;
            vs2_q     <= SYNC_IDLE;
`ifdef TEMPORAL_DITHER_EN
            frame_q   <= 2'd0;
`endif
        end else begin
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            hs_prev_q <= hs_prev_d;
            vs_prev_q <= vs_prev_d;
            r1_q      <= r1_d;
            g1_q      <= g1_d;
            b1_q      <= b1_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            t1_q      <= t1_d;
            r2_q      <= r2_d;
            g2_q      <= g2_d;
            b2_q      <= b2_d;
            hs2_q     <= hs2_d;
            vs2_q     <= vs2_d;
`ifdef TEMPORAL_DITHER_EN
            frame_q   <= frame_d;
`endif
        end
    end

    assign VGA_R_OUT  = r2_q;
    assign VGA_G_OUT  = g2_q;
    assign VGA_B_OUT  = b2_q;
    assign VGA_HS_OUT = hs2_q;
    assign VGA_VS_OUT = vs2_q;

endmodule
